// File: rtl/fpgifa_pkg.sv
// Types and default frame geometry shared by the recover, dither and capture stages.
package fpgifa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDrain
    } cap_state_e;

    localparam int unsigned DefaultHPixels = 320;
    localparam int unsigned DefaultVPixels = 240;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO of {last, byte} entries with synchronous flush.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [8:0] wdata,
    input  logic       pop,
    output logic [8:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [8:0]     mem_q [DEPTH];
    logic [AddrW:0] wr_ptr_q, rd_ptr_q;
    logic           do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/frame_byte_packer.sv
// Captures one dithered 1-bit frame on request and streams it out packed 8 pixels per byte.
module frame_byte_packer
    import fpgifa_pkg::*;
#(
    parameter int unsigned H_PIXELS   = DefaultHPixels,
    parameter int unsigned V_PIXELS   = DefaultVPixels,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        capture_in,
    input  logic        pixel_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        valid_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid_out,
    input  logic        byte_ready_in,
    output logic        byte_last_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out
);

    localparam int unsigned FrameBytes = H_PIXELS * V_PIXELS / 8;
    localparam int unsigned ByteCntW   = $clog2(FrameBytes);

    logic [1:0]          rst_sync_q;
    logic                rst_n;
    cap_state_e          state_q, state_d;
    logic [10:0]         h_exp_q, h_exp_d;
    logic [9:0]          v_exp_q, v_exp_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [6:0]          shift_q, shift_d;
    logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
    logic                error_q, error_d, done_q, done_d;
    logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [8:0]          fifo_wdata, fifo_rdata;
    logic                pix_in_range, coord_match, last_byte, fault;

    // Assert asynchronously, release on the clock.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign pix_in_range = valid_in && (hcount_in < 11'(H_PIXELS)) && (vcount_in < 10'(V_PIXELS));
    assign coord_match  = (hcount_in == h_exp_q) && (vcount_in == v_exp_q);
    assign last_byte    = (byte_cnt_q == ByteCntW'(FrameBytes - 1));
    assign fifo_wdata   = {last_byte, shift_q, pixel_in};

    always_comb begin
        state_d    = state_q;
        h_exp_d    = h_exp_q;
        v_exp_d    = v_exp_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        error_d    = error_q;
        done_d     = 1'b0;
        fifo_push  = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            StIdle: begin
                h_exp_d    = '0;
                v_exp_d    = '0;
                bit_cnt_d  = '0;
                shift_d    = '0;
                byte_cnt_d = '0;
                if (capture_in) begin
                    state_d = StArmed;
                    error_d = 1'b0;
                end
            end
            // Expected coords sit at (0,0) while armed, so the same match starts the frame.
            StArmed, StCapture: begin
                if (pix_in_range && coord_match) begin
                    state_d   = StCapture;
                    shift_d   = {shift_q[5:0], pixel_in};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (h_exp_q == 11'(H_PIXELS - 1)) begin
                        h_exp_d = '0;
                        v_exp_d = v_exp_q + 10'd1;
                    end else begin
                        h_exp_d = h_exp_q + 11'd1;
                    end
                    if (bit_cnt_q == 3'd7) begin
                        if (fifo_full && !fifo_pop) begin
                            fault = 1'b1;
                        end else begin
                            fifo_push  = 1'b1;
                            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                            if (last_byte) state_d = StDrain;
                        end
                    end
                end else if (pix_in_range && state_q == StCapture) begin
                    fault = 1'b1;
                end
            end
            StDrain: begin
                if (fifo_pop && fifo_rdata[8]) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (fault) begin
            state_d    = StIdle;
            error_d    = 1'b1;
            fifo_push  = 1'b0;
            h_exp_d    = '0;
            v_exp_d    = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            byte_cnt_d = '0;
        end
        fifo_flush = fault;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            h_exp_q    <= '0;
            v_exp_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_exp_q    <= h_exp_d;
            v_exp_q    <= v_exp_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_byte_fifo (
        .clk  (clk_in),
        .rst_n(rst_n),
        .flush(fifo_flush),
        .push (fifo_push),
        .wdata(fifo_wdata),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign byte_valid_out = !fifo_empty;
    assign fifo_pop       = byte_valid_out && byte_ready_in;
    assign byte_out       = byte_valid_out ? fifo_rdata[7:0] : 8'h00;
    assign byte_last_out  = byte_valid_out && fifo_rdata[8];
    assign busy_out       = (state_q != StIdle);
    assign done_out       = done_q;
    assign error_out      = error_q;

endmodule

// File: tb/tb_frame_byte_packer.sv
// Scoreboard bench for frame_byte_packer on a reduced 32x8 frame (32 bytes, 36x10 raster).
module tb_frame_byte_packer;

    localparam int H  = 32;
    localparam int V  = 8;
    localparam int HT = 36;
    localparam int VT = 10;
    localparam int LastPos = HT * VT - 1;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        capture_in, pixel_in, valid_in, byte_ready_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [7:0]  byte_out;
    logic        byte_valid_out, byte_last_out, busy_out, done_out, error_out;

    int n_checks = 0;
    int n_errors = 0;
    int rx_count = 0;
    int done_count = 0;
    int exp_done = 0;
    int cap_at = -1;
    int drop_h = -1;
    int drop_v = -1;
    int mode = 0;
    bit model_on = 0;
    bit ready_rand = 0;
    logic [7:0] m_acc;
    int m_n;
    logic [8:0] exp_q[$];
    logic [8:0] first_rx, last_rx, held;
    bit stall = 0;

    frame_byte_packer #(
        .H_PIXELS  (H),
        .V_PIXELS  (V),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .capture_in    (capture_in),
        .pixel_in      (pixel_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .valid_in      (valid_in),
        .byte_out      (byte_out),
        .byte_valid_out(byte_valid_out),
        .byte_ready_in (byte_ready_in),
        .byte_last_out (byte_last_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .error_out     (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            stall = 0;
        end else begin
            if (byte_valid_out && stall)
                chk("hold_stable", 32'({byte_last_out, byte_out}), 32'(held));
            if (byte_valid_out && byte_ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'({byte_last_out, byte_out}), 32'h1ff);
                end else begin
                    chk("byte", 32'({byte_last_out, byte_out}), 32'(exp_q.pop_front()));
                end
                if (rx_count == 0) first_rx = {byte_last_out, byte_out};
                last_rx = {byte_last_out, byte_out};
                rx_count++;
            end
            stall = byte_valid_out && !byte_ready_in;
            held  = {byte_last_out, byte_out};
            if (done_out) done_count++;
        end
    end

    function automatic logic pix_fn(input int h, input int v);
        if (mode == 0) return h[0];
        return ((h == 7) && (v == 0)) || ((h == H - 1) && (v == V - 1));
    endfunction

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_capture();
        capture_in = 1'b1;
        cycle();
        capture_in = 1'b0;
    endtask

    task automatic start_model();
        model_on = 1;
        m_n = 0;
        m_acc = 8'h00;
    endtask

    task automatic drive(input int from, input int to);
        for (int p = from; p <= to; p++) begin
            int h;
            int v;
            logic pix;
            h = p % HT;
            v = p / HT;
            pix = pix_fn(h, v);
            hcount_in  = 11'(h);
            vcount_in  = 10'(v);
            pixel_in   = pix;
            valid_in   = !((h == drop_h) && (v == drop_v));
            capture_in = (p == cap_at);
            if (ready_rand) byte_ready_in = 1'($urandom_range(0, 1));
            if (model_on && h < H && v < V) begin
                if (!valid_in) begin
                    model_on = 0;
                end else begin
                    m_acc = {m_acc[6:0], pix};
                    m_n++;
                    if (m_n == 8) begin
                        exp_q.push_back({((h == H - 1) && (v == V - 1)), m_acc});
                        m_n = 0;
                    end
                end
            end
            cycle();
        end
        valid_in   = 1'b0;
        capture_in = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy_out && i < 400) begin
            cycle();
            i++;
        end
        chk("idle_timeout", 32'(busy_out), 32'd0);
    endtask

    task automatic frame_end(input int exp_bytes);
        wait_idle();
        cycle();
        cycle();
        model_on = 0;
        chk("byte_count", 32'(rx_count), 32'(exp_bytes));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_count), 32'(exp_done));
        chk("error_clear", 32'(error_out), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(byte_valid_out), 32'd0);
        chk({tag, "_byte"}, 32'(byte_out), 32'd0);
        chk({tag, "_last"}, 32'(byte_last_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_done"}, 32'(done_out), 32'd0);
        chk({tag, "_error"}, 32'(error_out), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b0;
        capture_in = 1'b0;
        pixel_in = 1'b0;
        valid_in = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        byte_ready_in = 1'b1;
        repeat (3) cycle();
        chk_outputs_zero("reset");
        rst_in = 1'b1;
        repeat (3) cycle();

        // Full frame of alternating pixels, always ready.
        mode = 0;
        rx_count = 0;
        pulse_capture();
        chk("armed_busy", 32'(busy_out), 32'd1);
        start_model();
        drive(0, LastPos);
        exp_done++;
        frame_end(32);

        // Two isolated white pixels, random backpressure.
        mode = 1;
        rx_count = 0;
        ready_rand = 1;
        pulse_capture();
        start_model();
        drive(0, LastPos);
        ready_rand = 0;
        byte_ready_in = 1'b1;
        exp_done++;
        frame_end(32);
        chk("first_byte", 32'(first_rx), 32'h001);
        chk("last_byte", 32'(last_rx), 32'h101);

        // Overflow: consumer never ready, 16 bytes fit, the 17th faults.
        mode = 0;
        rx_count = 0;
        byte_ready_in = 1'b0;
        pulse_capture();
        drive(0, 3 * HT + 31);
        chk("full_valid", 32'(byte_valid_out), 32'd1);
        chk("full_head", 32'(byte_out), 32'h55);
        chk("full_last", 32'(byte_last_out), 32'd0);
        chk("full_noerr", 32'(error_out), 32'd0);
        drive(3 * HT + 32, 4 * HT + 7);
        chk("ovf_error", 32'(error_out), 32'd1);
        chk("ovf_valid", 32'(byte_valid_out), 32'd0);
        chk("ovf_busy", 32'(busy_out), 32'd0);
        byte_ready_in = 1'b1;
        drive(4 * HT + 8, LastPos);
        chk("ovf_rx", 32'(rx_count), 32'd0);

        // Dropped pixel (5,3): error flagged on (6,3).
        rx_count = 0;
        pulse_capture();
        chk("err_cleared", 32'(error_out), 32'd0);
        drop_h = 5;
        drop_v = 3;
        start_model();
        drive(0, 3 * HT + 5);
        chk("drop_noerr_yet", 32'(error_out), 32'd0);
        drive(3 * HT + 6, 3 * HT + 6);
        chk("drop_error", 32'(error_out), 32'd1);
        chk("drop_valid", 32'(byte_valid_out), 32'd0);
        chk("drop_busy", 32'(busy_out), 32'd0);
        drive(3 * HT + 7, LastPos);
        drop_h = -1;
        drop_v = -1;
        chk("drop_rx", 32'(rx_count), 32'd12);
        chk("drop_queue", 32'(exp_q.size()), 32'd0);
        chk("drop_no_done", 32'(done_count), 32'(exp_done));

        rx_count = 0;
        pulse_capture();
        chk("recapture_err", 32'(error_out), 32'd0);
        start_model();
        drive(0, LastPos);
        exp_done++;
        frame_end(32);

        // Capture mid-frame waits for next (0,0); capture during CAPTURE ignored.
        rx_count = 0;
        cap_at = 3 * HT + 10;
        drive(0, LastPos);
        chk("midframe_armed", 32'(busy_out), 32'd1);
        chk("midframe_rx", 32'(rx_count), 32'd0);
        cap_at = 50;
        start_model();
        drive(0, LastPos);
        cap_at = -1;
        exp_done++;
        frame_end(32);

        // Capture coincident with (0,0) skips that frame.
        rx_count = 0;
        cap_at = 0;
        drive(0, LastPos);
        cap_at = -1;
        chk("coincident_armed", 32'(busy_out), 32'd1);
        chk("coincident_rx", 32'(rx_count), 32'd0);
        start_model();
        drive(0, LastPos);
        exp_done++;
        frame_end(32);

        // Reset in the middle of a capture.
        pulse_capture();
        start_model();
        drive(0, 3 * HT + 31);
        chk("prereset_busy", 32'(busy_out), 32'd1);
        rst_in = 1'b0;
        model_on = 0;
        exp_q.delete();
        cycle();
        chk_outputs_zero("midreset");
        cycle();
        rst_in = 1'b1;
        repeat (3) cycle();
        chk("postreset_busy", 32'(busy_out), 32'd0);
        rx_count = 0;
        pulse_capture();
        start_model();
        drive(0, LastPos);
        exp_done++;
        frame_end(32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
